// File: rtl/farrow_interp_pp.sv
// farrow_interp_pp: pipelined I/Q Farrow interpolator (linear or parabolic).
// Optional FARROW_SAT_EN: saturate results and flag ovf; otherwise wrap.
module farrow_interp_pp #(
  parameter int DW   = 16,
  parameter int MU_W = 16,
  parameter int MODE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_i,
  input  logic [DW-1:0]   in_q,
  input  logic            strobe,
  input  logic [MU_W-1:0] mu,
  output logic            out_valid,
  output logic [DW-1:0]   symbol_i,
  output logic [DW-1:0]   symbol_q,
  output logic            strb_drop,
  output logic            ovf
);

  localparam int D1W = DW + 3;
  localparam int D2W = DW + 2;
  localparam int AW  = DW + MU_W + 4;
  localparam int BW  = DW + 2*MU_W + 5;
  localparam int YW  = BW + 1;
  localparam int FB  = 2*MU_W + 1;
  localparam int RW  = YW - FB;

  localparam logic signed [YW-1:0] HALF =
    YW'(1) <<< (FB - 1);

  logic signed [DW-1:0] smp [2];
  logic signed [DW-1:0] tap [2][4];
  logic signed [DW-1:0] nxt [2][4];
  logic [2:0]           fill;
  logic [2:0]           fill_nxt;
  logic                 accept;

  logic signed [D1W-1:0] d1_c [2];
  logic signed [D2W-1:0] d2_c [2];

  logic                  s1_v;
  logic signed [D1W-1:0] s1_d1 [2];
  logic signed [D2W-1:0] s1_d2 [2];
  logic signed [DW-1:0]  s1_t2 [2];
  logic [MU_W-1:0]       s1_mu;

  logic signed [AW-1:0]  mu_a;
  logic signed [AW-1:0]  a_c [2];

  logic                  s2_v;
  logic signed [AW-1:0]  s2_a [2];
  logic signed [DW-1:0]  s2_t2 [2];
  logic [MU_W-1:0]       s2_mu;

  logic signed [BW-1:0]  mu_b;
  logic signed [BW-1:0]  b_c [2];

  logic                  s3_v;
  logic signed [BW-1:0]  s3_b [2];
  logic signed [DW-1:0]  s3_t2 [2];

  logic signed [YW-1:0]  y_full [2];
  logic signed [RW-1:0]  y_int [2];
  logic [DW-1:0]         yo [2];
  logic                  clip [2];
  logic [DW-1:0]         sym [2];

  assign smp[0] = $signed(in_i);
  assign smp[1] = $signed(in_q);

  // Strobe sees the post-shift taps when a sample arrives in the same cycle
  always_comb begin
    fill_nxt = fill;
    nxt = tap;
    if (in_valid) begin
      if (fill != 3'd4) fill_nxt = fill + 3'd1;
      for (int r = 0; r < 2; r++) begin
        nxt[r][0] = smp[r];
        nxt[r][1] = tap[r][0];
        nxt[r][2] = tap[r][1];
        nxt[r][3] = tap[r][2];
      end
    end
  end

  assign accept = strobe && (fill_nxt == 3'd4);

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      if (MODE == 0) begin
        d1_c[r] = (D1W'(nxt[r][1])
                 - D1W'(nxt[r][2])) <<< 1;
        d2_c[r] = '0;
      end else begin
        d1_c[r] = D1W'(nxt[r][1])
                + (D1W'(nxt[r][1]) <<< 1)
                - D1W'(nxt[r][0])
                - D1W'(nxt[r][2])
                - D1W'(nxt[r][3]);
        d2_c[r] = D2W'(nxt[r][0])
                - D2W'(nxt[r][1])
                - D2W'(nxt[r][2])
                + D2W'(nxt[r][3]);
      end
    end
  end

  assign mu_a = AW'($signed({1'b0, s1_mu}));
  assign mu_b = BW'($signed({1'b0, s2_mu}));

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      a_c[r] = (AW'(s1_d1[r]) <<< MU_W)
             + AW'(s1_d2[r]) * mu_a;
      b_c[r] = BW'(s2_a[r]) * mu_b;
    end
  end

  // b carries 2*MU_W fraction bits; halving adds one more
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      y_full[r] = (YW'(s3_t2[r]) <<< FB)
                + YW'(s3_b[r]) + HALF;
      y_int[r]  = y_full[r][YW-1:FB];
      clip[r]   = !((&y_int[r][RW-1:DW-1])
                 || !(|y_int[r][RW-1:DW-1]));
`ifdef FARROW_SAT_EN
      if (clip[r])
        yo[r] = y_int[r][RW-1]
              ? {1'b1, {(DW-1){1'b0}}}
              : {1'b0, {(DW-1){1'b1}}};
      else
        yo[r] = y_int[r][DW-1:0];
`else
      yo[r] = y_int[r][DW-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill      <= '0;
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s3_v      <= 1'b0;
      out_valid <= 1'b0;
      strb_drop <= 1'b0;
      ovf       <= 1'b0;
      s1_mu     <= '0;
      s2_mu     <= '0;
      for (int r = 0; r < 2; r++) begin
        for (int k = 0; k < 4; k++)
          tap[r][k] <= '0;
        s1_d1[r] <= '0;
        s1_d2[r] <= '0;
        s1_t2[r] <= '0;
        s2_a[r]  <= '0;
        s2_t2[r] <= '0;
        s3_b[r]  <= '0;
        s3_t2[r] <= '0;
        sym[r]   <= '0;
      end
    end else begin
      fill      <= fill_nxt;
      tap       <= nxt;
      strb_drop <= strobe && !accept;
      s1_v      <= accept;
      s2_v      <= s1_v;
      s3_v      <= s2_v;
      out_valid <= s3_v;
`ifdef FARROW_SAT_EN
      ovf <= s3_v && (clip[0] || clip[1]);
`else
      ovf <= 1'b0;
`endif
      if (accept) begin
        s1_mu <= mu;
        for (int r = 0; r < 2; r++) begin
          s1_d1[r] <= d1_c[r];
          s1_d2[r] <= d2_c[r];
          s1_t2[r] <= nxt[r][2];
        end
      end
      if (s1_v) begin
        s2_mu <= s1_mu;
        for (int r = 0; r < 2; r++) begin
          s2_a[r]  <= a_c[r];
          s2_t2[r] <= s1_t2[r];
        end
      end
      if (s2_v) begin
        for (int r = 0; r < 2; r++) begin
          s3_b[r]  <= b_c[r];
          s3_t2[r] <= s2_t2[r];
        end
      end
      if (s3_v) begin
        for (int r = 0; r < 2; r++)
          sym[r] <= yo[r];
      end
    end
  end

  assign symbol_i = sym[0];
  assign symbol_q = sym[1];

endmodule

// File: tb/tb_farrow_interp_pp.sv
// tb_farrow_interp_pp: directed checks of the Farrow interpolator.
// Runs a parabolic and a linear instance side by side.
module tb_farrow_interp_pp;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_i;
  logic [15:0] in_q;
  logic        strobe;
  logic [15:0] mu;

  logic        out_valid;
  logic [15:0] symbol_i;
  logic [15:0] symbol_q;
  logic        strb_drop;
  logic        ovf;

  logic        l_out_valid;
  logic [15:0] l_symbol_i;
  logic [15:0] l_symbol_q;
  logic        l_strb_drop;
  logic        l_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  farrow_interp_pp #(.DW(16), .MU_W(16), .MODE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q),
    .strobe(strobe), .mu(mu),
    .out_valid(out_valid),
    .symbol_i(symbol_i), .symbol_q(symbol_q),
    .strb_drop(strb_drop), .ovf(ovf)
  );

  farrow_interp_pp #(.DW(16), .MU_W(16), .MODE(0)) dut_lin (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q),
    .strobe(strobe), .mu(mu),
    .out_valid(l_out_valid),
    .symbol_i(l_symbol_i), .symbol_q(l_symbol_q),
    .strb_drop(l_strb_drop), .ovf(l_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    strobe = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input int vi, input int vq);
    in_valid = 1'b1;
    in_i = 16'(vi);
    in_q = 16'(vq);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic fire(input logic [15:0] m);
    strobe = 1'b1;
    mu = m;
    tick();
    strobe = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (symbol_i !== 16'd0 || symbol_q !== 16'd0) begin
      errors++;
      $display("FAIL reset_symbol: got %h/%h want 0/0",
               symbol_i, symbol_q);
    end
    checks++;
    if (strb_drop !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: drop=%b ovf=%b want 0/0",
               strb_drop, ovf);
    end
  endtask

  task automatic test_ramp();
    logic [15:0] ei, eq;
    do_reset();
    push(1000, -1000);
    push(2000, -2000);
    push(3000, -3000);
    push(4000, -4000);
    for (int s = 0; s < 2; s++) begin
      fire(s == 0 ? 16'h0000 : 16'h8000);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL ramp_early_valid%0d_c%0d: got %b want 0",
                   s, c, out_valid);
        end
        tick();
      end
      ei = (s == 0) ? 16'd2000 : 16'd2500;
      eq = -ei;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL ramp_valid%0d: got %b want 1", s, out_valid);
      end
      checks++;
      if (symbol_i !== ei || symbol_q !== eq) begin
        errors++;
        $display("FAIL ramp_value%0d: got %0d/%0d want %0d/%0d",
                 s, $signed(symbol_i), $signed(symbol_q),
                 $signed(ei), $signed(eq));
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL ramp_pulse%0d: got %b want 0", s, out_valid);
      end
    end
  endtask

  task automatic test_drop();
    logic seen;
    do_reset();
    push(1000, 1000);
    push(2000, 2000);
    push(3000, 3000);
    fire(16'h8000);
    checks++;
    if (strb_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse: got %b want 1", strb_drop);
    end
    tick();
    checks++;
    if (strb_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_clear: got %b want 0", strb_drop);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_output: got %b want 0", seen);
    end
  endtask

  task automatic test_modes();
    do_reset();
    push(0, 0);
    push(1000, -1000);
    push(0, 0);
    push(0, 0);
    fire(16'h8000);
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || l_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL modes_valid: got %b/%b want 1/1",
               out_valid, l_out_valid);
    end
    checks++;
    if (symbol_i !== 16'd625 || symbol_q !== 16'hFD8F) begin
      errors++;
      $display("FAIL modes_parabolic: got %0d/%0d want 625/-625",
               $signed(symbol_i), $signed(symbol_q));
    end
    checks++;
    if (l_symbol_i !== 16'd500 || l_symbol_q !== 16'hFE0C) begin
      errors++;
      $display("FAIL modes_linear: got %0d/%0d want 500/-500",
               $signed(l_symbol_i), $signed(l_symbol_q));
    end
  endtask

  task automatic test_overflow();
    logic [15:0] ei;
    logic        eo;
`ifdef FARROW_SAT_EN
    ei = 16'h7FFF;
    eo = 1'b1;
`else
    ei = 16'hBFFF;
    eo = 1'b0;
`endif
    do_reset();
    push(-32768, -32768);
    push(32767, 32767);
    push(32767, 32767);
    push(-32768, -32768);
    fire(16'h8000);
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_valid: got %b want 1", out_valid);
    end
    checks++;
    if (symbol_i !== ei || symbol_q !== ei) begin
      errors++;
      $display("FAIL ovf_value: got %0d/%0d want %0d",
               $signed(symbol_i), $signed(symbol_q), $signed(ei));
    end
    checks++;
    if (ovf !== eo) begin
      errors++;
      $display("FAIL ovf_flag: got %b want %b", ovf, eo);
    end
    tick();
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pulse: got %b want 0", ovf);
    end
  endtask

  task automatic test_same_cycle();
    logic seen;
    do_reset();
    push(1000, 1000);
    push(2000, 2000);
    push(3000, 3000);
    in_valid = 1'b1;
    in_i = 16'd4000;
    in_q = 16'd4000;
    strobe = 1'b1;
    mu = 16'h8000;
    tick();
    in_valid = 1'b0;
    strobe = 1'b0;
    checks++;
    if (strb_drop !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_drop: got %b want 0", strb_drop);
    end
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || symbol_i !== 16'd2500
        || symbol_q !== 16'd2500) begin
      errors++;
      $display("FAIL same_cycle_value: v=%b got %0d/%0d want 2500",
               out_valid, $signed(symbol_i), $signed(symbol_q));
    end
    fire(16'h0000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: got %b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] mus [4];
    logic [15:0] exps [4];
    mus  = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
    exps = '{16'd2000, 16'd2250, 16'd2500, 16'd2750};
    do_reset();
    push(1000, 1000);
    push(2000, 2000);
    push(3000, 3000);
    push(4000, 4000);
    strobe = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mu = mus[k];
      tick();
    end
    strobe = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || symbol_i !== exps[k]
          || symbol_q !== exps[k]) begin
        errors++;
        $display("FAIL b2b_%0d: v=%b got %0d/%0d want %0d",
                 k, out_valid, $signed(symbol_i),
                 $signed(symbol_q), exps[k]);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got %b want 0", out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_i = '0;
    in_q = '0;
    strobe = 1'b0;
    mu = '0;
    test_reset();
    test_ramp();
    test_drop();
    test_modes();
    test_overflow();
    test_same_cycle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
